branch_predict_unit: RTL

- Parametrised successor to the combinational branch resolver in the execute stage.
- Keeps the execute-stage outputs PC_Imm, PC_Four, BrPC and PcSel, and adds a direct-mapped branch target buffer (BTB) with saturating counters.
- Fetch stage: predicts taken/not-taken and the target.
- Execute stage: resolves the branch, raises a redirect only on mispredict, and trains the table.

---
 rtl/branch_predict_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolver with a direct-mapped BTB for fetch prediction.
// Define BRANCH_STATS_EN to add the Br_Count / Mispred_Count statistics ports.
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] F_PC,
  output logic            F_PredTaken,
  output logic [31:0]     F_PredTarget,
  input  logic [PC_W-1:0] Cur_PC,
  input  logic [31:0]     Imm,
  input  logic            Ex_Valid,
  input  logic            Ex_Branch,
  input  logic            Ex_Cond,
  input  logic            Ex_PredTaken,
  input  logic [31:0]     Ex_PredTarget,
  output logic [31:0]     PC_Imm,
  output logic [31:0]     PC_Four,
  output logic [31:0]     BrPC,
  output logic            PcSel
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     Br_Count,
  output logic [31:0]     Mispred_Count
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(2 ** (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(2 ** (CNT_W - 1) - 1);

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_q   [ENTRIES];

  logic             valid_d;
  logic [TAG_W-1:0] tag_d;
  logic [PC_W-1:0]  tgt_d;
  logic [CNT_W-1:0] cnt_d;
  logic             wr_en;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = F_PC[IDX_W+1:2];
  assign f_tag = F_PC[PC_W-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign F_PredTaken  = f_hit && cnt_q[f_idx][CNT_W-1];
  assign F_PredTarget = F_PredTaken ? 32'(tgt_q[f_idx])
                                    : 32'(F_PC) + 32'd4;

  logic [31:0] pc_full;
  logic        resolve;
  logic        mispred;

  assign pc_full = 32'(Cur_PC);
  assign PC_Imm  = pc_full + Imm;
  assign PC_Four = pc_full + 32'd4;
  assign resolve = Ex_Valid && Ex_Branch;
  assign mispred = (Ex_Cond != Ex_PredTaken) ||
                   (Ex_Cond && (Ex_PredTarget != PC_Imm));
  assign PcSel   = resolve && mispred;
  assign BrPC    = !resolve ? '0 : (Ex_Cond ? PC_Imm : PC_Four);

  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;
  logic             imm_ok;

  assign e_idx  = Cur_PC[IDX_W+1:2];
  assign e_tag  = Cur_PC[PC_W-1:IDX_W+2];
  assign e_hit  = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign imm_ok = (PC_Imm[31:PC_W] == '0);

  always_comb begin
    wr_en   = 1'b0;
    valid_d = valid_q[e_idx];
    tag_d   = tag_q[e_idx];
    tgt_d   = tgt_q[e_idx];
    cnt_d   = cnt_q[e_idx];
    if (resolve) begin
      if (e_hit) begin
        wr_en = 1'b1;
        if (Ex_Cond) begin
          tgt_d = PC_Imm[PC_W-1:0];
          if (cnt_q[e_idx] != CNT_MAX) cnt_d = cnt_q[e_idx] + CNT_W'(1);
        end else if (cnt_q[e_idx] != '0) begin
          cnt_d = cnt_q[e_idx] - CNT_W'(1);
        end
      end else if (Ex_Cond && imm_ok) begin
        // Targets outside the PC range cannot be stored, so skip allocation.
        wr_en   = 1'b1;
        valid_d = 1'b1;
        tag_d   = e_tag;
        tgt_d   = PC_Imm[PC_W-1:0];
        cnt_d   = CNT_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else if (wr_en) begin
      valid_q[e_idx] <= valid_d;
      tag_q[e_idx]   <= tag_d;
      tgt_q[e_idx]   <= tgt_d;
      cnt_q[e_idx]   <= cnt_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_q;
  logic [31:0] mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (resolve) br_q <= br_q + 32'd1;
      if (PcSel) mis_q <= mis_q + 32'd1;
    end
  end

  assign Br_Count      = br_q;
  assign Mispred_Count = mis_q;
`endif

  logic unused_pc;
  assign unused_pc = ^{F_PC[1:0], Cur_PC[1:0]};

endmodule
